// File: rtl/joy_debounce_if.sv
// Joypad conditioner bus: raw active-low pins from the board, debounced key
// vector and strobes toward the Game Boy core keypad input.
interface joy_debounce_if;
   logic [7:0] joy_n;
   logic [7:0] key;
   logic [7:0] key_press;
   logic       key_changed;

   modport master (output joy_n, input key, key_press, key_changed);
   modport slave  (input joy_n, output key, key_press, key_changed);
endinterface

// File: rtl/joy_debounce.sv
// Two-flop synchroniser plus per-button debounce counter for the eight joypad pins.
// Optional opposing-direction (SOCD) cleaning of the D-pad: define JOY_SOCD_CLEAN_EN.
module joy_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_WIDTH       = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   joy_debounce_if.slave joy_bus
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [7:0]           r_s1;
   logic [7:0]           r_s2;
   logic [7:0]           r_stable;
   logic [7:0]           r_key;
   logic [7:0]           r_key_press;
   logic                 r_key_changed;
   logic [CNT_WIDTH-1:0] r_cnt [8];

   logic [7:0]           w_stable_next;
   logic [7:0]           w_key_raw;
   logic [7:0]           w_key_next;
   logic [CNT_WIDTH-1:0] w_cnt_next [8];

   // A bit flips only after its synchronised level has disagreed with stable for
   // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
   always_comb begin
      // NOTE: defaults first so every path assigns every bit; otherwise a latch is inferred.
      w_stable_next = r_stable;
      for (int i = 0; i < 8; i++) begin
         w_cnt_next[i] = r_cnt[i];
         if (r_s2[i] == r_stable[i]) begin
            w_cnt_next[i] = '0;
         end else if (r_cnt[i] == CNT_LAST) begin
            w_stable_next[i] = r_s2[i];
            w_cnt_next[i]    = '0;
         end else begin
            w_cnt_next[i] = r_cnt[i] + 1'b1;
         end
      end
   end

   assign w_key_raw = ~w_stable_next;

`ifdef JOY_SOCD_CLEAN_EN
   // Both directions of an axis held together reads as neither.
   always_comb begin
      w_key_next = w_key_raw;
      if (w_key_raw[5] && w_key_raw[4]) w_key_next[5:4] = 2'b00;
      if (w_key_raw[7] && w_key_raw[6]) w_key_next[7:6] = 2'b00;
   end
`else
   assign w_key_next = w_key_raw;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1          <= '1;
         r_s2          <= '1;
         r_stable      <= '1;
         r_key         <= '0;
         r_key_press   <= '0;
         r_key_changed <= 1'b0;
         // NOTE: the counter array is tiny and must restart cleanly, so it is reset like any flop.
         for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
      end else begin
         // NOTE: non-blocking so r_s2 takes the old r_s1, giving a true two-stage chain.
         r_s1          <= joy_bus.joy_n;
         r_s2          <= r_s1;
         r_stable      <= w_stable_next;
         r_cnt         <= w_cnt_next;
         r_key         <= w_key_next;
         r_key_press   <= w_key_next & ~r_key;
         r_key_changed <= |(w_key_next ^ r_key);
      end
   end

   assign joy_bus.key         = r_key;
   assign joy_bus.key_press   = r_key_press;
   assign joy_bus.key_changed = r_key_changed;

endmodule
